// File: rtl/i2c_bus_state_ctrl.sv
// I2C bus state tracker: synchronizes SCL/SDA, detects START/STOP,
// tracks IDLE/BUSY/FREE_WAIT, counts bits per byte, captures the ACK
// bit and flags arbitration loss for the local master.
module i2c_bus_state_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int BUS_FREE_CYCLES = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       master_en,
  input  logic       sda_drive_low,
  output logic       start_det,
  output logic       rep_start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic [3:0] bit_cnt,
  output logic       byte_done,
  output logic       ack_bit,
  output logic       arb_lost
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    FREE_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] FREE_LAST = 8'(BUS_FREE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_p_q, scl_p_d;
  logic                   sda_p_q, sda_p_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             free_cnt_q, free_cnt_d;
  logic                   ack_bit_q, ack_bit_d;
  logic                   start_det_q, start_det_d;
  logic                   rep_start_det_q, rep_start_det_d;
  logic                   stop_det_q, stop_det_d;
  logic                   byte_done_q, byte_done_d;
  logic                   arb_lost_q, arb_lost_d;

  logic scl_s, sda_s;
  logic sda_fall, sda_rise, scl_rise;
  logic start_ev, stop_ev;

  // Synchronizer shift and previous-sample capture
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_p_d    = scl_s;
    sda_p_d    = sda_s;
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign sda_fall = sda_p_q & ~sda_s;
  assign sda_rise = ~sda_p_q & sda_s;
  assign scl_rise = ~scl_p_q & scl_s;
  // SCL must be high on both samples, so an SDA edge alongside an SCL edge is ignored
  assign start_ev = scl_p_q & scl_s & sda_fall;
  assign stop_ev  = scl_p_q & scl_s & sda_rise;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; START outranks the free-wait timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_ev) state_d = BUSY;
      BUSY:      if (stop_ev)  state_d = FREE_WAIT;
      FREE_WAIT: begin
        if (start_ev)                      state_d = BUSY;
        else if (free_cnt_q == FREE_LAST)  state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Output/datapath next values: pulses, bit counter, free counter, ACK capture
  always_comb begin
    bit_cnt_d       = bit_cnt_q;
    free_cnt_d      = free_cnt_q;
    ack_bit_d       = ack_bit_q;
    start_det_d     = 1'b0;
    rep_start_det_d = 1'b0;
    stop_det_d      = 1'b0;
    byte_done_d     = 1'b0;
    arb_lost_d      = ((state_q == BUSY) & master_en & ~sda_drive_low & scl_rise & ~sda_s) |
                      ((start_ev | stop_ev) & master_en & sda_drive_low);
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          start_det_d = 1'b1;
          bit_cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        if (start_ev) begin
          rep_start_det_d = 1'b1;
          bit_cnt_d       = 4'd0;
        end else if (stop_ev) begin
          stop_det_d = 1'b1;
          bit_cnt_d  = 4'd0;
          free_cnt_d = 8'd0;
        end else if (scl_rise) begin
          if (bit_cnt_q == 4'd8) begin
            byte_done_d = 1'b1;
            ack_bit_d   = sda_s;
            bit_cnt_d   = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      FREE_WAIT: begin
        if (start_ev) begin
          start_det_d = 1'b1;
          bit_cnt_d   = 4'd0;
          free_cnt_d  = 8'd0;
        end else if (free_cnt_q != FREE_LAST) begin
          free_cnt_d = free_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Synchronizer, datapath and registered pulse flops
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      scl_sync_q      <= '1;
      sda_sync_q      <= '1;
      scl_p_q         <= 1'b1;
      sda_p_q         <= 1'b1;
      bit_cnt_q       <= 4'd0;
      free_cnt_q      <= 8'd0;
      ack_bit_q       <= 1'b1;
      start_det_q     <= 1'b0;
      rep_start_det_q <= 1'b0;
      stop_det_q      <= 1'b0;
      byte_done_q     <= 1'b0;
      arb_lost_q      <= 1'b0;
    end else begin
      scl_sync_q      <= scl_sync_d;
      sda_sync_q      <= sda_sync_d;
      scl_p_q         <= scl_p_d;
      sda_p_q         <= sda_p_d;
      bit_cnt_q       <= bit_cnt_d;
      free_cnt_q      <= free_cnt_d;
      ack_bit_q       <= ack_bit_d;
      start_det_q     <= start_det_d;
      rep_start_det_q <= rep_start_det_d;
      stop_det_q      <= stop_det_d;
      byte_done_q     <= byte_done_d;
      arb_lost_q      <= arb_lost_d;
    end
  end

  assign start_det     = start_det_q;
  assign rep_start_det = rep_start_det_q;
  assign stop_det      = stop_det_q;
  assign bus_busy      = (state_q != IDLE);
  assign bit_cnt       = bit_cnt_q;
  assign byte_done     = byte_done_q;
  assign ack_bit       = ack_bit_q;
  assign arb_lost      = arb_lost_q;

endmodule
